// File: rtl/vedic_div_8by4.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : vedic_div_8by4                                                   |
// | Function : Iterative restoring divider, one quotient bit per CALC cycle.    |
// |            Define VEDIC_DIV_ZERO_DETECT_EN to short-circuit divisor == 0.   |
// | Revision : 1.0 - initial release                                            |
// +-----------------------------------------------------------------------------+
module vedic_div_8by4 #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero
);

    localparam int         c_CNT_W = $clog2(DIVIDEND_W + 1);
    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CALC  = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [DIVIDEND_W-1:0] r_dvd;
    logic [DIVISOR_W-1:0]  r_dvs;
    logic [DIVISOR_W:0]    r_prem;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [DIVIDEND_W-1:0] r_quo;
    logic [DIVISOR_W-1:0]  r_rem;
    logic                  w_accept;
    logic                  w_last;
    logic                  w_zero_in;
    logic [DIVISOR_W:0]    w_shift;
    logic                  w_ge;
    logic [DIVISOR_W:0]    w_step;

    assign w_accept = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last   = (r_state == c_CALC) && (r_cnt == c_CNT_W'(DIVIDEND_W - 1));

`ifdef VEDIC_DIV_ZERO_DETECT_EN
    assign w_zero_in = (divisor == '0);
`else
    assign w_zero_in = 1'b0;
`endif

    // Dividend register shifts out its MSB and collects quotient bits at the LSB.
    assign w_shift = {r_prem[DIVISOR_W-1:0], r_dvd[DIVIDEND_W-1]};
    assign w_ge    = (w_shift >= {1'b0, r_dvs});
    assign w_step  = w_ge ? (w_shift - {1'b0, r_dvs}) : w_shift;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_state_nxt = w_zero_in ? c_DONE : c_CALC;
            end
            c_CALC: begin
                if (w_last) w_state_nxt = c_DONE;
            end
            c_DONE: begin
                if (start) w_state_nxt = w_zero_in ? c_DONE : c_CALC;
                else       w_state_nxt = c_IDLE;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

`ifdef VEDIC_DIV_ZERO_DETECT_EN
    logic r_dbz;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_prem <= '0;
            r_cnt  <= '0;
            r_quo  <= '0;
            r_rem  <= '0;
`ifdef VEDIC_DIV_ZERO_DETECT_EN
            r_dbz  <= 1'b0;
`endif
        end else if (w_accept) begin
            r_dvd  <= dividend;
            r_dvs  <= divisor;
            r_prem <= '0;
            r_cnt  <= '0;
            if (w_zero_in) begin
                r_quo <= '1;
                r_rem <= '0;
`ifdef VEDIC_DIV_ZERO_DETECT_EN
                r_dbz <= 1'b1;
`endif
            end
        end else if (r_state == c_CALC) begin
            r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_ge};
            r_prem <= w_step;
            r_cnt  <= r_cnt + 1'b1;
            if (w_last) begin
                r_quo <= {r_dvd[DIVIDEND_W-2:0], w_ge};
                // A zero divisor leaves dividend bits in the partial remainder; report 0.
                r_rem <= (r_dvs == '0) ? '0 : w_step[DIVISOR_W-1:0];
`ifdef VEDIC_DIV_ZERO_DETECT_EN
                r_dbz <= 1'b0;
`endif
            end
        end
    end

    assign busy      = (r_state == c_CALC);
    assign done      = (r_state == c_DONE);
    assign quotient  = r_quo;
    assign remainder = r_rem;
`ifdef VEDIC_DIV_ZERO_DETECT_EN
    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire
